ustc_spmv_array: RTL and testbench

- Unstructured-sparse tensor-core compute array: N_UNIT lanes each hold one nonzero of a sparse matrix A (value, column index, row tag, control).
- Each lane gathers the dense-vector element B[col] through a crossbar, multiplies, then a segmented reduction sums all lanes of the same row.
- Each row's sum is delivered on that row's segment-end lane.
- Sits inside the sparse tensor core between the operand staging buffers and the accumulator/writeback.

---
 rtl/ustc_pkg.sv | 17 +
 rtl/ustc_xbar.sv | 23 ++
 rtl/ustc_spmv_array.sv | 88 ++++++++
 tb/tb_ustc_spmv_array.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ustc_pkg.sv
// Shared widths, lane counts and control-bit positions for the sparse MV array.
package ustc_pkg;
  localparam int N_UNIT    = 32;
  localparam int NUM_XBAR  = 4;
  localparam int N_XBAR_IN = 8;
  localparam int DW_DATA   = 8;
  localparam int DW_ROW    = 4;
  localparam int DW_CTRL   = 4;
  localparam int DW_IDX    = 4;
  localparam int DW_OUT    = 16;

  // Bit positions inside each lane's control nibble.
  localparam int CTRL_START  = 0;
  localparam int CTRL_END    = 1;
  localparam int CTRL_SINGLE = 2;
  localparam int CTRL_MULTI  = 3;
endpackage

// File: rtl/ustc_xbar.sv
// Mux crossbar: each output lane picks B[idx]. An index beyond the vector
// length selects zero, so out-of-range columns contribute nothing.
import ustc_pkg::*;

module ustc_xbar (
  input  logic [N_XBAR_IN*DW_DATA-1:0] b,
  input  logic [N_XBAR_IN*DW_IDX-1:0]  idx,
  output logic [N_XBAR_IN*DW_DATA-1:0] sel
);

  // Per-output compare-and-select against every B element.
  always_comb begin
    sel = '0;
    for (int o = 0; o < N_XBAR_IN; o++) begin
      for (int k = 0; k < N_XBAR_IN; k++) begin
        if (idx[o*DW_IDX +: DW_IDX] == DW_IDX'(k)) begin
          sel[o*DW_DATA +: DW_DATA] = b[k*DW_DATA +: DW_DATA];
        end
      end
    end
  end

endmodule

// File: rtl/ustc_spmv_array.sv
// Sparse tensor-core compute array: gather B by column, multiply per lane
// (stage 1), then a segmented running sum delivered on each segment's end
// lane (stage 2). Fully pipelined, one batch per clock, no handshake.
import ustc_pkg::*;

module ustc_spmv_array (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_UNIT*DW_DATA-1:0]   in_a,
  input  logic [N_XBAR_IN*DW_DATA-1:0] in_b,
  input  logic [N_UNIT*DW_IDX-1:0]    in_a_col,
  input  logic [N_UNIT*DW_ROW-1:0]    in_a_row,
  input  logic [N_UNIT*DW_CTRL-1:0]   in_a_ctrl,
  output logic [N_UNIT*DW_OUT-1:0]    out
);

  // Row tags travel with the data for debug visibility only; segmentation
  // is driven purely by the control bits.
  logic row_unused;
  assign row_unused = ^in_a_row;

  logic [N_UNIT*DW_DATA-1:0]         b_sel;
  logic [N_UNIT-1:0][DW_OUT-1:0]     prod_d;
  logic [N_UNIT-1:0][DW_OUT-1:0]     prod_q;
  logic [N_UNIT-1:0]                 start_q;
  logic [N_UNIT-1:0]                 end_q;
  logic [N_UNIT*DW_OUT-1:0]          out_d;
  logic [DW_OUT-1:0]                 carry;
  logic [DW_OUT-1:0]                 sum;

  // One crossbar per group of N_XBAR_IN consecutive lanes, all fed the same B.
  for (genvar x = 0; x < NUM_XBAR; x++) begin : g_xbar
    ustc_xbar u_xbar (
      .b   (in_b),
      .idx (in_a_col[x*N_XBAR_IN*DW_IDX +: N_XBAR_IN*DW_IDX]),
      .sel (b_sel[x*N_XBAR_IN*DW_DATA +: N_XBAR_IN*DW_DATA])
    );
  end

  // Lane products; idle lanes are forced to zero.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      if (in_a_ctrl[i*DW_CTRL + CTRL_MULTI] || in_a_ctrl[i*DW_CTRL + CTRL_SINGLE]) begin
        prod_d[i] = DW_OUT'(in_a[i*DW_DATA +: DW_DATA]) * DW_OUT'(b_sel[i*DW_DATA +: DW_DATA]);
      end
    end
  end

  // Stage 1 register: products plus the start/end flags needed downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      prod_q <= prod_d;
      for (int i = 0; i < N_UNIT; i++) begin
        start_q[i] <= in_a_ctrl[i*DW_CTRL + CTRL_START];
        end_q[i]   <= in_a_ctrl[i*DW_CTRL + CTRL_END];
      end
    end
  end

  // Segmented running sum. A start lane discards whatever was accumulating
  // (so an unclosed segment is dropped), an end lane emits and clears the
  // carry, and a segment that never ends simply never emits.
  always_comb begin
    carry = '0;
    sum   = '0;
    out_d = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      sum = (start_q[i] ? '0 : carry) + prod_q[i];
      out_d[i*DW_OUT +: DW_OUT] = end_q[i] ? sum : '0;
      carry = end_q[i] ? '0 : sum;
    end
  end

  // Stage 2 register: per-lane results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= '0;
    end else begin
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_ustc_spmv_array.sv
// Directed bench for ustc_spmv_array with hand-computed expected values.
module tb_ustc_spmv_array;
  localparam int NU = 32;

  logic             clk;
  logic             reset;
  logic [NU*8-1:0]  in_a;
  logic [8*8-1:0]   in_b;
  logic [NU*4-1:0]  in_a_col;
  logic [NU*4-1:0]  in_a_row;
  logic [NU*4-1:0]  in_a_ctrl;
  logic [NU*16-1:0] out;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_full[NU];

  ustc_spmv_array dut (
    .clk       (clk),
    .reset     (reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_a_col  (in_a_col),
    .in_a_row  (in_a_row),
    .in_a_ctrl (in_a_ctrl),
    .out       (out)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Scoreboard compare
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lane(input int i);
    return out[i*16 +: 16];
  endfunction

  // Driver helpers
  task automatic clear_inputs();
    in_a = '0; in_a_col = '0; in_a_row = '0; in_a_ctrl = '0;
  endtask

  task automatic set_b_ramp();
    for (int k = 0; k < 8; k++) in_b[k*8 +: 8] = 8'(k);
  endtask

  task automatic set_lane(input int i, input int val, input int col, input logic [3:0] ctrl);
    in_a[i*8 +: 8]      = 8'(val);
    in_a_col[i*4 +: 4]  = 4'(col);
    in_a_ctrl[i*4 +: 4] = ctrl;
  endtask

  task automatic seg_ctrl(input int lo, input int hi, input int row);
    for (int i = lo; i <= hi; i++) begin
      in_a_ctrl[i*4 +: 4] = (i == lo) ? 4'b1001 : (i == hi) ? 4'b1010 : 4'b1000;
      in_a_row[i*4 +: 4]  = 4'(row);
    end
  endtask

  task automatic load_full_batch();
    int va[NU];
    int cl[NU];
    va = '{7,6,4,3,1,0, 6,5,3,2,1,0, 5, 7, 7,6,4,3,2,1,0, 5,1, 7,6,5,4,3,2,1,0, 2};
    cl = '{0,1,3,4,6,7, 0,1,2,3,5,6, 5, 7, 0,1,2,3,4,6,7, 1,5, 0,1,2,3,4,5,6,7, 2};
    clear_inputs();
    set_b_ramp();
    for (int i = 0; i < NU; i++) set_lane(i, va[i], cl[i], 4'b0000);
    seg_ctrl(0, 5, 0);
    seg_ctrl(6, 11, 1);
    in_a_ctrl[12*4 +: 4] = 4'b0111;
    in_a_ctrl[13*4 +: 4] = 4'b0111;
    seg_ctrl(14, 20, 4);
    seg_ctrl(21, 22, 5);
    seg_ctrl(23, 30, 6);
    in_a_ctrl[31*4 +: 4] = 4'b0111;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NU; i++) check_val($sformatf("%s_l%0d", tag, i), lane(i), 16'd0);
  endtask

  // Main sequence
  initial begin
    reset = 1'b0;
    clear_inputs();
    in_b = '0;
    repeat (2) @(negedge clk);
    check_all_zero("rst_state");

    // Full batch held through reset; result 2 edges after release.
    load_full_batch();
    for (int i = 0; i < NU; i++) exp_full[i] = 16'd0;
    exp_full[5] = 16'd36;  exp_full[11] = 16'd22; exp_full[12] = 16'd25;
    exp_full[13] = 16'd49; exp_full[20] = 16'd37; exp_full[22] = 16'd10;
    exp_full[30] = 16'd56; exp_full[31] = 16'd4;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NU; i++) check_val($sformatf("full_l%0d", i), lane(i), exp_full[i]);

    // Overflow: one 32-lane segment of 255*255.
    clear_inputs();
    for (int k = 0; k < 8; k++) in_b[k*8 +: 8] = 8'd255;
    for (int i = 0; i < NU; i++) set_lane(i, 255, i % 8, 4'b0000);
    seg_ctrl(0, 31, 0);
    repeat (2) @(negedge clk);
    check_val("ovf_l31", lane(31), 16'd49184);
    check_val("ovf_l30", lane(30), 16'd0);
    check_val("ovf_l0", lane(0), 16'd0);

    // Idle lanes with nonzero data.
    clear_inputs();
    set_b_ramp();
    for (int i = 0; i < NU; i++) set_lane(i, 9, 3, 4'b0000);
    repeat (2) @(negedge clk);
    check_all_zero("idle");

    // Implicit close, out-of-range column, unterminated tail segment.
    clear_inputs();
    set_b_ramp();
    set_lane(0, 1, 1, 4'b1001);
    set_lane(1, 1, 1, 4'b1000);
    set_lane(2, 2, 1, 4'b1001);
    set_lane(3, 3, 1, 4'b1010);
    set_lane(4, 3, 9, 4'b0111);
    set_lane(5, 3, 4, 4'b0111);
    set_lane(28, 9, 7, 4'b1001);
    set_lane(29, 9, 7, 4'b1000);
    set_lane(30, 9, 7, 4'b1000);
    set_lane(31, 9, 7, 4'b1000);
    repeat (2) @(negedge clk);
    check_val("iclose_l1", lane(1), 16'd0);
    check_val("iclose_l2", lane(2), 16'd0);
    check_val("iclose_l3", lane(3), 16'd5);
    check_val("colrange_l4", lane(4), 16'd0);
    check_val("single_l5", lane(5), 16'd12);
    for (int i = 28; i < NU; i++) check_val($sformatf("unterm_l%0d", i), lane(i), 16'd0);

    // Pipelining: new batch every cycle, each checked exactly 2 cycles later.
    for (int j = 0; j < 12; j++) begin
      if (j >= 2) begin
        check_val($sformatf("pipe%0d_l0", j - 2), lane(0), exp_q.pop_front());
        check_val($sformatf("pipe%0d_l31", j - 2), lane(31), exp_q.pop_front());
      end
      clear_inputs();
      set_b_ramp();
      if (j < 8) begin
        set_lane(0, j + 3, 2, 4'b0111);
        set_lane(31, j, 7, 4'b0111);
        exp_q.push_back(16'(2 * (j + 3)));
        exp_q.push_back(16'(7 * j));
      end else begin
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
      end
      @(negedge clk);
    end
    exp_q.delete();

    // Async reset mid-cycle, then recovery latency.
    load_full_batch();
    repeat (2) @(negedge clk);
    check_val("prerst_l5", lane(5), 16'd36);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_val("rst_hold_l5", lane(5), 16'd0);
    reset = 1'b1;
    @(negedge clk);
    check_val("rel_edge1_l5", lane(5), 16'd0);
    @(negedge clk);
    check_val("rel_edge2_l5", lane(5), 16'd36);
    check_val("rel_edge2_l30", lane(30), 16'd56);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
